req_encoder_32to5: RTL and testbench
====================================

REQ_ENCODER_32TO5 -- requirements
Module: req_encoder_32to5

Interface
REQ-001 Parameter: NREQ, 32, number of request lines; fixed at 32 in this revision.
REQ-002 Parameter: IDX_W, 5, encoded index width; SHALL equal log2(NREQ).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_in  input  32  request set pulses; bit i high for one cycle marks request i pending.
REQ-006 clr_all  input  1  synchronous flush of all pending requests and of the output stage.
REQ-007 out_idx  output  5  binary index of the presented request.
REQ-008 out_valid  output  1  out_idx holds a valid claimed request.
REQ-009 out_ready  input  1  consumer accepts out_idx when out_valid and out_ready are both high.
REQ-010 pending  output  32  registered pending vector, excluding the index held in the output stage.
REQ-011 busy  output  1  high when pending is nonzero or out_valid is high.

Function
REQ-012 Pending update each edge: pending_next = (pending | req_in) & ~claim_mask, where claim_mask is one-hot at the index loaded this edge, else zero.
REQ-013 Selection SHALL use the registered pending only; a req_in bit becomes eligible one edge after it is sampled.
REQ-014 Priority: fixed; lowest set index wins (bit 0 highest priority).
REQ-015 Output stage states: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-016 EMPTY -> HOLD when pending != 0: load out_idx with the selected index and clear that bit in pending on the same edge.
REQ-017 HOLD with out_valid & out_ready: if pending != 0, reload the next selected index on that edge (stay HOLD); else go to EMPTY.
REQ-018 HOLD without out_ready: out_idx and out_valid SHALL remain stable; no claim occurs.
REQ-019 Latency: req_in bit sampled at edge t -> pending bit set after edge t -> out_valid high after edge t+1 (2 cycles from idle); throughput one index per cycle under continuous out_ready.
REQ-020 Re-request of the index currently held in HOLD SHALL set its pending bit again (served a second time after the current one).
REQ-021 A req_in bit already pending SHALL have no additional effect (no counting, no overflow).
REQ-022 req_in for an index being claimed on the same edge SHALL leave that bit set in pending (set wins over claim).
REQ-023 clr_all: at the next edge pending = 0, out_valid = 0, state = EMPTY; req_in sampled in the same cycle is discarded; out_ready in that cycle is ignored.
REQ-024 out_idx in EMPTY SHALL retain its last value; consumers SHALL ignore it.
REQ-025 busy SHALL be combinational from registered state only (no input-to-output path).

Reset
REQ-026 On reset_n low, asynchronously: pending = 0, out_valid = 0, out_idx = 0, state = EMPTY.
REQ-027 Reset asserted mid-HOLD SHALL drop the held index without acceptance; requests are lost.
REQ-028 After reset_n deasserts, the first claim SHALL occur no earlier than the second rising edge.

Structure
REQ-029 Shared package: NREQ, IDX_W constants and the two-value output-state enum (EMPTY, HOLD).
REQ-030 One sub-module: prio_enc_32to5, combinational find-first-set of a 32-bit vector producing a 5-bit index and an any flag; it SHALL be the inverse of the existing 5-to-32 decoder for one-hot inputs.
REQ-031 Claim mask SHALL be generated by the existing 5-to-32 decoder from the selected index.

Verification
REQ-032 Single request: req_in=0x0000_0100 at cycle 0, out_ready=1 -> out_valid=1, out_idx=8 after edge 1; out_valid=0 after edge 2.
REQ-033 Priority and back-to-back: req_in=0x8000_0005 in one cycle, out_ready=1 -> out_idx sequence 0, 2, 31 on three consecutive cycles; pending 0x8000_0004, 0x8000_0000, 0 alongside.
REQ-034 Backpressure: pending 0x0000_0030, out_ready=0 for 5 cycles -> out_idx=4 stable, pending=0x0000_0020; raise out_ready -> 4 accepted, then 5.
REQ-035 Re-request while held: hold idx 3, pulse req_in=0x0000_0008 -> pending=0x0000_0008; after acceptance out_idx=3 presented again.
REQ-036 Flush: pending 0xFFFF_FFFE, HOLD idx 0, clr_all with req_in=0x1 same cycle -> next edge pending=0, out_valid=0, busy=0.
REQ-037 Async reset mid-HOLD: drop reset_n between edges -> out_valid, pending, out_idx zero immediately, before the next clock edge.

Source files
------------

// File: rtl/req_encoder_32to5_pkg.sv
// Shared constants, output-stage state type and the 5-to-32 decoder
// used to build the one-hot claim mask.
package req_encoder_32to5_pkg;

   localparam int NREQ  = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } out_state_e;

   function automatic logic [NREQ-1:0] dec_5to32(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] one_hot;
      one_hot = {{(NREQ-1){1'b0}}, 1'b1};
      return one_hot << idx;
   endfunction

endpackage

// File: rtl/req_encoder_32to5_prio_enc.sv
// Combinational find-first-set: lowest set bit wins. For a one-hot input it
// returns exactly the index that dec_5to32 would expand back to that vector.
module prio_enc_32to5
   import req_encoder_32to5_pkg::*;
(
   input  logic [NREQ-1:0]  i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      o_idx = '0;
      // Walk from the top down so the lowest set bit is the last (winning) assignment.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = IDX_W'(i);
      end
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/req_encoder_32to5.sv
// Pending-request collector with a one-entry output stage: lowest pending
// index is claimed into the output register and handed off with valid/ready.
module req_encoder_32to5
   import req_encoder_32to5_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req_in,
   input  logic             clr_all,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   output logic [NREQ-1:0]  pending,
   output logic             busy
);

   out_state_e       r_state;
   out_state_e       w_state_next;
   logic [NREQ-1:0]  r_pending;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_sel_idx;
   logic             w_any;
   logic             w_load;
   logic [NREQ-1:0]  w_claim_mask;

   // Selection looks only at registered pending, never at req_in.
   prio_enc_32to5 u_prio_enc (
      .i_vec (r_pending),
      .o_idx (w_sel_idx),
      .o_any (w_any)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) r_state <= EMPTY;
      else          r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (clr_all) begin
         w_state_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY:   if (w_any) w_state_next = HOLD;
            HOLD:    if (out_ready && !w_any) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
         endcase
      end
   end

   // Output / claim logic: a claim happens whenever the stage is free or being drained.
   always_comb begin
      out_valid    = (r_state == HOLD);
      w_load       = !clr_all && w_any && (!out_valid || out_ready);
      w_claim_mask = w_load ? dec_5to32(w_sel_idx) : '0;
   end

   // A fresh request beats a claim of the same bit, so it is OR-ed in after clearing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
         r_idx     <= '0;
      end else begin
         if (clr_all) r_pending <= '0;
         else         r_pending <= (r_pending & ~w_claim_mask) | req_in;
         if (w_load)  r_idx     <= w_sel_idx;
      end
   end

   assign out_idx = r_idx;
   assign pending = r_pending;
   assign busy    = (|r_pending) || (r_state == HOLD);

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Randomised and directed bench for req_encoder_32to5 against a set-based
// reference model of the pending pool and the one-entry output stage.
module tb_req_encoder_32to5;

   logic        clock;
   logic        reset_n;
   logic [31:0] req_in;
   logic        clr_all;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic        out_valid;
   logic [31:0] pending;
   logic        busy;

   int vectors;
   int miscompares;

   // Reference model: a pool of outstanding request numbers plus a held slot.
   bit m_pool[32];
   bit m_valid;
   int m_idx;

   req_encoder_32to5 dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_in    (req_in),
      .clr_all   (clr_all),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   function automatic int model_lowest();
      for (int i = 0; i < 32; i++) if (m_pool[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] model_pool_vec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) if (m_pool[i]) v = v + (32'd1 << i);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_pool[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
   endtask

   task automatic model_step(input logic [31:0] r, input logic c, input logic rd);
      int sel;
      if (c) begin
         for (int i = 0; i < 32; i++) m_pool[i] = 1'b0;
         m_valid = 1'b0;
         return;
      end
      sel = model_lowest();
      if (m_valid && rd) m_valid = 1'b0;     // current item handed off
      if (sel >= 0 && !m_valid) begin
         m_pool[sel] = 1'b0;
         m_valid     = 1'b1;
         m_idx       = sel;
      end
      for (int i = 0; i < 32; i++) if (r[i]) m_pool[i] = 1'b1;
   endtask

   // Compare process: advance the model on every live edge, check just after it.
   always @(posedge clock) begin
      if (reset_n) begin
         model_step(req_in, clr_all, out_ready);
         #1;
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("out_idx",   32'(out_idx),   32'(m_idx));
         check("pending",   pending,        model_pool_vec());
         check("busy",      32'(busy),      32'(m_valid || model_pool_vec() != 0));
      end
   end

   task automatic cyc(input logic [31:0] r, input logic c, input logic rd);
      req_in    = r;
      clr_all   = c;
      out_ready = rd;
      @(posedge clock);
      #2;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_reset();
      reset_n   = 1'b0;
      req_in    = '0;
      clr_all   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_valid",   32'(out_valid), 32'd0);
      check("rst_idx",     32'(out_idx),   32'd0);
      check("rst_pending", pending,        32'd0);
      check("rst_busy",    32'(busy),      32'd0);
      @(negedge clock) reset_n = 1'b1;

      // Single request
      cyc(32'h0000_0100, 1'b0, 1'b1);
      check("single_pend", pending, 32'h0000_0100);
      check("single_v0",   32'(out_valid), 32'd0);
      cyc('0, 1'b0, 1'b1);
      check("single_v1",   32'(out_valid), 32'd1);
      check("single_idx",  32'(out_idx),   32'd8);
      cyc('0, 1'b0, 1'b1);
      check("single_v2",   32'(out_valid), 32'd0);

      // Priority and back-to-back
      cyc(32'h8000_0005, 1'b0, 1'b1);
      cyc('0, 1'b0, 1'b1);
      check("b2b_idx0",  32'(out_idx), 32'd0);
      check("b2b_pend0", pending, 32'h8000_0004);
      cyc('0, 1'b0, 1'b1);
      check("b2b_idx1",  32'(out_idx), 32'd2);
      check("b2b_pend1", pending, 32'h8000_0000);
      cyc('0, 1'b0, 1'b1);
      check("b2b_idx2",  32'(out_idx), 32'd31);
      check("b2b_pend2", pending, 32'h0000_0000);
      check("b2b_valid", 32'(out_valid), 32'd1);
      cyc('0, 1'b0, 1'b1);

      // Backpressure
      cyc(32'h0000_0030, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc('0, 1'b0, 1'b0);
         check("bp_idx",  32'(out_idx), 32'd4);
         check("bp_pend", pending, 32'h0000_0020);
      end
      cyc('0, 1'b0, 1'b1);
      check("bp_next", 32'(out_idx), 32'd5);
      cyc('0, 1'b0, 1'b1);
      check("bp_done", 32'(out_valid), 32'd0);

      // Re-request while held
      cyc(32'h0000_0008, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0);
      cyc(32'h0000_0008, 1'b0, 1'b0);
      check("rereq_pend", pending, 32'h0000_0008);
      cyc('0, 1'b0, 1'b1);
      check("rereq_idx",  32'(out_idx), 32'd3);
      check("rereq_v",    32'(out_valid), 32'd1);
      cyc('0, 1'b0, 1'b1);

      // Flush with same-cycle request
      cyc(32'hFFFF_FFFF, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0);
      check("flush_pre", pending, 32'hFFFF_FFFE);
      cyc(32'h0000_0001, 1'b1, 1'b1);
      check("flush_pend",  pending, 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_busy",  32'(busy), 32'd0);

      // Asynchronous reset mid-HOLD
      cyc(32'h0000_0030, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_pend",  pending, 32'd0);
      check("arst_idx",   32'(out_idx), 32'd0);
      model_reset();
      @(negedge clock) reset_n = 1'b1;
      cyc(32'h0000_0004, 1'b0, 1'b1);
      check("post_rst_v0", 32'(out_valid), 32'd0);
      cyc('0, 1'b0, 1'b1);
      check("post_rst_idx", 32'(out_idx), 32'd2);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] r;
         logic        c;
         logic        rd;
         r = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 3) == 0) r = '0;
         else if ($urandom_range(0, 3) == 0) r = 32'd1 << $urandom_range(0, 31);
         c  = ($urandom_range(0, 63) == 0);
         rd = ($urandom_range(0, 3) != 0);
         cyc(r, c, rd);
      end
      for (int n = 0; n < 40; n++) cyc('0, 1'b0, 1'b1);
      check("drain_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
